// File: rtl/boa_mdu_pkg.sv
// boa_mdu_pkg -- shared types, constants and helpers for the MDU sequencer.
//   mdu_op_t    : RV32M funct3 encodings.
//   mdu_state_t : sequencer FSM states.
//   DIV0_QUOT / INT_MIN : RISC-V special-case result constants.
package boa_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} mdu_state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic is_div_op(input mdu_op_t op);
    return op[2];
  endfunction

  // MUL is treated as signed x signed; its low word is identical either way.
  function automatic logic mul_lhs_signed(input mdu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU};
  endfunction

  function automatic logic mul_rhs_signed(input mdu_op_t op);
    return op inside {OP_MUL, OP_MULH};
  endfunction

  function automatic logic div_signed(input mdu_op_t op);
    return op inside {OP_DIV, OP_REM};
  endfunction

  // Picks the architectural result word for an op from the raw arithmetic.
  function automatic logic [31:0] select_result(input mdu_op_t op, input logic [63:0] prod,
                                                input logic [31:0] quot, input logic [31:0] rem);
    case (op)
      OP_MUL:                         return prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   return prod[63:32];
      OP_DIV, OP_DIVU:                return quot;
      default:                        return rem;
    endcase
  endfunction

endpackage

// File: rtl/boa_mdu_seq_if.sv
// boa_mdu_seq_if -- request/result handshake bundle of the MDU sequencer.
//   req_* : issue side (valid/ready, funct3 op, rs1/rs2 values, tag).
//   res_* : result side (valid/ready, 32-bit data, tag).
//   master: issue logic + result consumer.  slave: the sequencer.
interface boa_mdu_seq_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_lhs;
  logic [31:0]      req_rhs;
  logic [TAG_W-1:0] req_tag;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output req_valid, req_op, req_lhs, req_rhs, req_tag, res_ready,
    input  req_ready, res_valid, res_data, res_tag
  );

  modport slave (
    input  req_valid, req_op, req_lhs, req_rhs, req_tag, res_ready,
    output req_ready, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/boa_div_simple.sv
// boa_div_simple -- combinational 32-bit divider (quotient + remainder).
//   a, b      : dividend, divisor.
//   is_signed : signed (DIV/REM) or unsigned (DIVU/REMU) division.
//   quot, rem : results; zero divisor yields zeros (resolved upstream).
module boa_div_simple
  import boa_mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] quot,
  output logic [31:0] rem
);
  always_comb begin
    quot = '0;
    rem  = '0;
    if (b != '0) begin
      if (!is_signed) begin
        quot = a / b;
        rem  = a % b;
      end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
        // Overflow case kept out of the signed divider datapath.
        quot = INT_MIN;
        rem  = '0;
      end else begin
        quot = $signed(a) / $signed(b);
        rem  = $signed(a) % $signed(b);
      end
    end
  end
endmodule

// File: rtl/boa_mdu_special.sv
// boa_mdu_special -- combinational RISC-V divide special-case detector.
//   op, lhs, rhs : incoming request.
//   hit          : request is divide-by-zero or signed overflow.
//   value        : architectural result for that case.
module boa_mdu_special
  import boa_mdu_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  output logic        hit,
  output logic [31:0] value
);
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned (no latch).
    hit   = 1'b0;
    value = '0;
    if (is_div_op(op)) begin
      if (rhs == '0) begin
        hit   = 1'b1;
        value = (op inside {OP_DIV, OP_DIVU}) ? DIV0_QUOT : lhs;
      end else if (div_signed(op) && lhs == INT_MIN && rhs == 32'hFFFF_FFFF) begin
        hit   = 1'b1;
        value = (op == OP_DIV) ? INT_MIN : '0;
      end
    end
  end
endmodule

// File: rtl/boa_mul_simple.sv
// boa_mul_simple -- combinational 32x32 -> 64 multiplier with per-operand signedness.
//   a, b               : operands.
//   a_signed, b_signed : treat operand as two's complement.
//   prod               : full 64-bit product.
module boa_mul_simple (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        a_signed,
  input  logic        b_signed,
  output logic [63:0] prod
);
  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [63:0] full;

  // A 33-bit signed extension covers both the signed and the unsigned reading.
  assign a_ext = {a_signed & a[31], a};
  assign b_ext = {b_signed & b[31], b};
  assign full  = a_ext * b_ext;
  assign prod  = full;
endmodule

// File: rtl/boa_mdu_seq.sv
// boa_mdu_seq -- RV32M multiply/divide sequencer.
// Latches one request per handshake, lets the combinational multiplier/divider
// settle for LATENCY cycles, resolves divide special cases in one cycle and
// holds the result until the consumer takes it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   flush      : drop any in-flight or held op.
//   bus        : boa_mdu_seq_if.slave (req_* / res_* handshakes).
//   busy       : sequencer not idle.
// Optional feature: define BOA_MDU_PAIR_CACHE_EN to keep the last product and
// the last quotient/remainder pair so a matching follow-up op completes in one cycle.
module boa_mdu_seq
  import boa_mdu_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  boa_mdu_seq_if.slave        bus,
  output logic                busy
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  mdu_op_t          op_q;
  logic [31:0]      lhs_q, rhs_q;
  logic [TAG_W-1:0] tag_q;
  logic             res_valid_q;
  logic [31:0]      res_data_q;
  logic [TAG_W-1:0] res_tag_q;

  mdu_op_t     req_op;
  logic        accept;
  logic        sp_hit, cache_hit, fast_hit;
  logic [31:0] sp_value, cache_value, fast_value;

  assign req_op        = mdu_op_t'(bus.req_op);
  assign bus.req_ready = !flush && (state == IDLE || (state == DONE && bus.res_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign busy          = (state != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;

  // Single-cycle latency has no time to latch first, so the arithmetic then
  // sees the request directly; otherwise it works off the latched operands.
  mdu_op_t     src_op;
  logic [31:0] src_lhs, src_rhs;
  logic [63:0] prod;
  logic [31:0] quot, rem, arith_res;

  assign src_op  = (LATENCY == 1) ? req_op      : op_q;
  assign src_lhs = (LATENCY == 1) ? bus.req_lhs : lhs_q;
  assign src_rhs = (LATENCY == 1) ? bus.req_rhs : rhs_q;

  boa_mul_simple u_mul (
    .a(src_lhs), .b(src_rhs),
    .a_signed(mul_lhs_signed(src_op)), .b_signed(mul_rhs_signed(src_op)),
    .prod(prod)
  );

  boa_div_simple u_div (
    .a(src_lhs), .b(src_rhs), .is_signed(div_signed(src_op)),
    .quot(quot), .rem(rem)
  );

  assign arith_res = select_result(src_op, prod, quot, rem);

  boa_mdu_special u_special (
    .op(req_op), .lhs(bus.req_lhs), .rhs(bus.req_rhs),
    .hit(sp_hit), .value(sp_value)
  );

`ifdef BOA_MDU_PAIR_CACHE_EN
  logic        norm_done;
  logic        mc_vld, dc_vld;
  logic [65:0] mc_key, req_mkey, src_mkey;
  logic [64:0] dc_key, req_dkey, src_dkey;
  logic [63:0] mc_prod;
  logic [31:0] dc_quot, dc_rem;

  // A normal (non-special) op produces its arithmetic result this cycle.
  assign norm_done = !flush && ((state == EXEC && cnt == '0) ||
                     (LATENCY == 1 && accept && !sp_hit && !cache_hit));

  assign req_mkey = {bus.req_lhs, bus.req_rhs, !mul_lhs_signed(req_op), !mul_rhs_signed(req_op)};
  assign req_dkey = {bus.req_lhs, bus.req_rhs, !div_signed(req_op)};
  assign src_mkey = {src_lhs, src_rhs, !mul_lhs_signed(src_op), !mul_rhs_signed(src_op)};
  assign src_dkey = {src_lhs, src_rhs, !div_signed(src_op)};

  assign cache_hit   = is_div_op(req_op) ? (dc_vld && dc_key == req_dkey)
                                         : (mc_vld && mc_key == req_mkey);
  assign cache_value = select_result(req_op, mc_prod, dc_quot, dc_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_vld <= 1'b0;
      dc_vld <= 1'b0;
    end else if (norm_done) begin
      if (is_div_op(src_op)) dc_vld <= 1'b1;
      else                   mc_vld <= 1'b1;
    end
  end

  // NOTE: entry payloads carry no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (norm_done) begin
      if (is_div_op(src_op)) begin
        dc_key  <= src_dkey;
        dc_quot <= quot;
        dc_rem  <= rem;
      end else begin
        mc_key  <= src_mkey;
        mc_prod <= prod;
      end
    end
  end
`else
  assign cache_hit   = 1'b0;
  assign cache_value = '0;
`endif

  assign fast_hit   = sp_hit || cache_hit;
  assign fast_value = sp_hit ? sp_value : cache_value;

  // NOTE: state uses non-blocking assignments; a later assignment in this block
  // overrides an earlier one, so the accept branch wins over the DONE->IDLE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_MUL;
      lhs_q       <= '0;
      rhs_q       <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else if (flush) begin
      state       <= IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          if (cnt == '0) begin
            state       <= DONE;
            res_valid_q <= 1'b1;
            res_data_q  <= arith_res;
            res_tag_q   <= tag_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        op_q  <= req_op;
        lhs_q <= bus.req_lhs;
        rhs_q <= bus.req_rhs;
        tag_q <= bus.req_tag;
        if (fast_hit || LATENCY == 1) begin
          state       <= DONE;
          res_valid_q <= 1'b1;
          res_data_q  <= fast_hit ? fast_value : arith_res;
          res_tag_q   <= bus.req_tag;
        end else begin
          state <= EXEC;
          cnt   <= CNT_W'(LATENCY - 2);
        end
      end
    end
  end
endmodule

// File: tb/tb_boa_mdu_seq.sv
// tb_boa_mdu_seq -- self-checking bench for boa_mdu_seq (LATENCY=2, TAG_W=5).
// Directed cases plus randomized ops against an arithmetic reference model
// that also tracks the optional pair cache when BOA_MDU_PAIR_CACHE_EN is set.
module tb_boa_mdu_seq;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 5;
  localparam int BUDGET  = 20;

  localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
  localparam logic [2:0] T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  boa_mdu_seq_if #(.TAG_W(TAG_W)) bus ();

  boa_mdu_seq #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model of the pair cache: last computed product / division key.
  bit          m_vld, d_vld;
  logic [31:0] m_lhs, m_rhs, d_lhs, d_rhs;
  int          m_cls;
  bit          d_u;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] lhs,
                                             input logic [31:0] rhs);
    longint sa, sb, ua, ub, p;
    bit     ovf;
    sa  = longint'($signed(lhs));
    sb  = longint'($signed(rhs));
    ua  = longint'({32'b0, lhs});
    ub  = longint'({32'b0, rhs});
    ovf = (lhs == 32'h8000_0000) && (rhs == 32'hFFFF_FFFF);
    case (op)
      T_MUL:    begin p = sa * sb; return p[31:0];  end
      T_MULH:   begin p = sa * sb; return p[63:32]; end
      T_MULHSU: begin p = sa * ub; return p[63:32]; end
      T_MULHU:  begin p = ua * ub; return p[63:32]; end
      T_DIV: begin
        if (rhs == 0) return 32'hFFFF_FFFF;
        if (ovf)      return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      T_DIVU: begin
        if (rhs == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      T_REM: begin
        if (rhs == 0) return lhs;
        if (ovf)      return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (rhs == 0) return lhs;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Expected accept-to-valid latency of an op that will complete; updates the cache model.
  task automatic ref_latency(input logic [2:0] op, input logic [31:0] lhs, input logic [31:0] rhs,
                             output int lat);
    bit special, hit;
    int cls;
    special = (op >= T_DIV) && (rhs == 0 ||
              ((op == T_DIV || op == T_REM) && lhs == 32'h8000_0000 && rhs == 32'hFFFF_FFFF));
    cls = (op == T_MULHSU) ? 1 : (op == T_MULHU) ? 2 : 0;
    hit = 1'b0;
    if (special) begin
      lat = 1;
    end else begin
`ifdef BOA_MDU_PAIR_CACHE_EN
      if (op < T_DIV) hit = m_vld && m_lhs == lhs && m_rhs == rhs && m_cls == cls;
      else            hit = d_vld && d_lhs == lhs && d_rhs == rhs && d_u == (op == T_DIVU || op == T_REMU);
`endif
      lat = hit ? 1 : LATENCY;
      if (!hit) begin
        if (op < T_DIV) begin
          m_vld = 1'b1; m_lhs = lhs; m_rhs = rhs; m_cls = cls;
        end else begin
          d_vld = 1'b1; d_lhs = lhs; d_rhs = rhs; d_u = (op == T_DIVU || op == T_REMU);
        end
      end
    end
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] lhs, input logic [31:0] rhs,
                           input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_lhs   = lhs;
    bus.req_rhs   = rhs;
    bus.req_tag   = tag;
  endtask

  // Called right after the accept edge; returns at the negedge where res_valid is seen.
  task automatic await_result(input string name, input int exp_lat, input logic [31:0] exp_val,
                              input logic [TAG_W-1:0] exp_tag);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < BUDGET) begin
      @(negedge clk);
      lat++;
      check({name, " busy"}, busy, 1);
      if (bus.res_valid) seen = 1'b1;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " data"}, bus.res_data, exp_val);
    check({name, " tag"}, bus.res_tag, exp_tag);
  endtask

  // Full transaction from IDLE with res_ready high; ends in the drive phase after the handshake.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] lhs,
                       input logic [31:0] rhs, input logic [TAG_W-1:0] tag, input logic [31:0] exp_val);
    int lat;
    ref_latency(op, lhs, rhs, lat);
    bus.res_ready = 1'b1;
    drive_req(op, lhs, rhs, tag);
    @(negedge clk);
    check({name, " idle"}, busy, 0);
    check({name, " req_ready"}, bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    await_result(name, lat, exp_val, tag);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    bit          saw;
    logic [2:0]  op;
    logic [31:0] lhs, rhs, prev_lhs, prev_rhs;
    logic [TAG_W-1:0] tag;

    m_vld = 1'b0; d_vld = 1'b0;
    rst_n = 1'b0; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_lhs = '0; bus.req_rhs = '0; bus.req_tag = '0;
    bus.res_ready = 1'b1;

    // Reset state.
    #12;
    check("reset res_valid", bus.res_valid, 0);
    check("reset res_data", bus.res_data, 0);
    check("reset res_tag", bus.res_tag, 0);
    check("reset busy", busy, 0);
    #10 rst_n = 1'b1;
    #1 check("reset req_ready", bus.req_ready, 1);
    @(posedge clk); #1;

    // Multiplies.
    issue("mul 7x6", T_MUL, 32'd7, 32'd6, 5'd3, 32'd42);
    issue("mulh -1x-1", T_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0);
    issue("mulhu", T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
    issue("mulhsu", T_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF);

    // Special cases (one-cycle).
    issue("div by 0", T_DIV, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF);
    issue("remu by 0", T_REMU, 32'd5, 32'd0, 5'd8, 32'd5);
    issue("div ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    issue("rem ovf", T_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0);

    // Held result, then back-to-back accept on the handshake cycle.
    ref_latency(T_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    bus.res_ready = 1'b0;
    drive_req(T_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
    @(negedge clk);
    check("div req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    await_result("div -7/2", lat, 32'hFFFF_FFFD, 5'd9);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("hold data", bus.res_data, 32'hFFFF_FFFD);
      check("hold valid", bus.res_valid, 1);
      check("hold req_ready", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    ref_latency(T_REM, 32'hFFFF_FFF9, 32'd2, lat);
    bus.res_ready = 1'b1;
    drive_req(T_REM, 32'hFFFF_FFF9, 32'd2, 5'd10);
    @(negedge clk);
    check("b2b req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    await_result("rem -7/2", lat, 32'hFFFF_FFFF, 5'd10);
    @(posedge clk); #1;

    // Flush during EXEC: the op vanishes.
    drive_req(T_MUL, 32'd1234, 32'd5678, 5'd21);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush idle", busy, 0);
    saw = bus.res_valid;
    repeat (4) begin
      @(negedge clk);
      if (bus.res_valid) saw = 1'b1;
    end
    check("flush no result", saw, 0);

    // Flush with a same-cycle request: nothing is accepted.
    @(posedge clk); #1;
    drive_req(T_MUL, 32'd3, 32'd4, 5'd22);
    flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush blocks accept", busy, 0);
    @(posedge clk); #1;

    // Division pair: second op may come from the cache.
    issue("divu 100/7", T_DIVU, 32'd100, 32'd7, 5'd13, 32'd14);
    issue("remu 100/7", T_REMU, 32'd100, 32'd7, 5'd14, 32'd2);

    // Asynchronous reset in the middle of EXEC.
    drive_req(T_MUL, 32'd3, 32'd3, 5'd15);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset res_valid", bus.res_valid, 0);
    check("midreset res_data", bus.res_data, 0);
    check("midreset res_tag", bus.res_tag, 0);
    m_vld = 1'b0; d_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized ops against the reference model.
    prev_lhs = 32'd1; prev_rhs = 32'd1;
    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 7));
      tag = TAG_W'($urandom);
      case ($urandom_range(0, 4))
        0: begin lhs = $urandom; rhs = 32'd0; end
        1: begin lhs = 32'h8000_0000; rhs = 32'hFFFF_FFFF; end
        2: begin lhs = prev_lhs; rhs = prev_rhs; end
        3: begin lhs = $urandom_range(0, 50) - 25; rhs = $urandom_range(0, 20) - 10; end
        default: begin lhs = $urandom; rhs = $urandom; end
      endcase
      issue("random", op, lhs, rhs, tag, ref_result(op, lhs, rhs));
      prev_lhs = lhs; prev_rhs = rhs;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/boa_mdu_seq.md
Name: boa_mdu_seq

Overview:
- Sequencer for RV32M multiply/divide ops, between the execute-stage issue logic and the combinational multiplier/divider.
- Accepts one request per valid/ready handshake and latches its operands.
- Lets the combinational arithmetic settle for a fixed, parameterised number of cycles (multicycle path), applies RISC-V special-case rules, and holds the result until the consumer takes it.

Parameters:
- LATENCY, 2, cycles from accept to res_valid for normal ops; legal range 1..8.
- TAG_W, 5, width of the opaque tag (destination register) carried with each request.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard in-flight/held op.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_lhs  in  32  rs1 value.
- req_rhs  in  32  rs2 value.
- req_tag  in  TAG_W  opaque tag.
- res_valid  out  1  result present.
- res_ready  in  1  consumer takes result.
- res_data  out  32  result.
- res_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, counter=0.
  - res_valid=0, res_data=0, res_tag=0, busy=0.
  - req_ready=1 once rst_n is high.
- FSM states IDLE, EXEC, DONE.
- IDLE:
  - req_ready = !flush.
  - On accept, latch op/lhs/rhs/tag.
  - Special case -> DONE next cycle. Else if LATENCY==1 -> DONE next cycle. Else -> EXEC, counter=LATENCY-2.
- EXEC:
  - req_ready=0.
  - Counter decrements each cycle; at 0 -> DONE.
  - res_data is registered on entry to DONE from the latched operands.
- DONE:
  - res_valid=1; data/tag stable until handshake.
  - req_ready = res_ready && !flush (back-to-back: the handshake and a new accept in the same cycle are legal).
  - After res_valid&&res_ready: new accept -> same transitions as IDLE; otherwise -> IDLE.
- Latency: accept at cycle T -> res_valid at T+LATENCY; special cases at T+1.
- Operand and result mapping:
  - MUL: product[31:0].
  - MULH: signed x signed, product[63:32].
  - MULHSU: signed lhs, unsigned rhs, product[63:32].
  - MULHU: unsigned x unsigned, product[63:32].
  - DIV/REM signed; DIVU/REMU unsigned.
- Special cases (registered, bypass the counter):
  - rhs==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> lhs.
  - DIV with lhs=0x80000000, rhs=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Flush:
  - Any state -> IDLE next cycle; res_valid=0 next cycle; result is dropped.
  - flush with req_valid in the same cycle: no accept.
  - flush overrides a same-cycle res_ready handshake: the result counts as consumed and dropped.
- Reset mid-operation: immediate return to reset values; no result is produced.
- Counter width: clog2(LATENCY) with a minimum of 1 bit.

Optional Feature:
- Macro BOA_MDU_PAIR_CACHE_EN.
- Defined:
  - Keeps the last computed 64-bit product with its key {lhs, rhs, u_lhs, u_rhs}, and the last div/mod pair with its key {lhs, rhs, u}. Each has its own valid bit, cleared on reset only.
  - A normal-path request whose key hits (e.g. MULH then MUL, DIV then REM on the same operands) goes IDLE/DONE -> DONE with res_valid at T+1.
  - Cache entries are written when a normal op reaches DONE.
  - Flush does not invalidate (results are pure functions of the key).
- Undefined: no cache storage; every normal op takes LATENCY cycles.

Decomposition:
- Package boa_mdu_pkg:
  - enum mdu_op_t (8 funct3 encodings).
  - enum mdu_state_t {IDLE, EXEC, DONE}.
  - Constants DIV0_QUOT=32'hFFFF_FFFF and INT_MIN=32'h8000_0000.
- Sub-module boa_mdu_special: combinational special-case detector and result, giving hit flag + 32-bit value.
- Arithmetic comes from existing boa_mul_simple and boa_div_simple instances fed from the latched operands.

Test Plan:
- LATENCY=2, MUL 7 x 6, res_ready=1: req at T -> res_valid at T+2, res_data=42, tag echoed; busy high at T+1..T+2.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0; MULHU on the same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Special cases at T+1:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000.
  - REM of the same operands -> 0.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. Hold res_ready=0 for 3 cycles: res_data stable, req_ready=0; then back-to-back accept on the handshake cycle.
- Flush during EXEC: no res_valid ever asserted for that tag; state IDLE next cycle. Assert rst_n=0 mid-EXEC: outputs reset asynchronously.
- BOA_MDU_PAIR_CACHE_EN: DIVU 100/7 (res_valid at T+LATENCY, 14) then REMU 100/7 -> res_valid at T+1, value 2. Without the macro the second op takes LATENCY cycles.
